tpu_job_seq: RTL and testbench
==============================

Name: tpu_job_seq

Overview:
Host-side job sequencer that sits directly upstream of the tpuv1 matrix unit and drives its r_w/addr/dataIn/dataOut MMIO-style port. It accepts one job descriptor (A, B and C base addresses in a 64-bit-word memory), then runs the whole job in order:
- fetches the A and B rows from memory and writes them into tpuv1;
- clears C and issues start;
- waits out the compute window;
- reads the C result words back out and writes them to memory.

It replaces host software stepping tpuv1 one MMIO access at a time.

Parameters:
DIM, 8, matrix dimension; rows of A, B and C.
DATAW, 64, data word width; equals the tpuv1 data width.
ADDRW, 16, tpuv1 address width.
MEM_AW, 32, memory word-address width.
COMPUTE_CYCLES, 4*DIM, cycles to wait after the start write before reading C.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
job_valid  in  1  job descriptor valid
job_ready  out  1  sequencer idle; descriptor accepted when valid&ready
a_base  in  MEM_AW  word address of A row 0; sampled at accept
b_base  in  MEM_AW  word address of B row 0; sampled at accept
c_base  in  MEM_AW  word address of the first C word; sampled at accept
job_done  out  1  one-cycle pulse when the last C word write is accepted
rd_valid  out  1  memory read request valid
rd_ready  in  1  memory read request accepted
rd_addr  out  MEM_AW  memory read word address
rsp_valid  in  1  read response valid; at most one outstanding
rsp_data  in  DATAW  read response data
wr_valid  out  1  memory write request valid
wr_ready  in  1  memory write request accepted
wr_addr  out  MEM_AW  memory write word address
wr_data  out  DATAW  memory write data
tpu_r_w  out  1  tpuv1 access type; 1 = write, 0 = read
tpu_addr  out  ADDRW  tpuv1 address
tpu_dataIn  out  DATAW  tpuv1 write data
tpu_dataOut  in  DATAW  tpuv1 read data; combinational, valid in the same cycle as addr

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: state IDLE; job_ready=1; job_done=0; rd_valid=0; wr_valid=0; tpu_r_w=0; tpu_addr=0; tpu_dataIn=0; all address and data registers 0.
- Reset mid-job: abandons the job and returns to IDLE next cycle. Late rsp_valid is ignored in IDLE.
- tpuv1 address map (fixed constants):
  - A row r write: 0x100 + 8*r.
  - B row write: 0x200. Each write shifts B in, so rows are written in order 0..DIM-1.
  - C row r: low half at 0x300 + 16*r, high half at 0x300 + 16*r + 8.
  - Start: write to 0x400.
- tpuv1 strobe rule: a tpuv1 access occupies exactly one cycle. Outside those cycles, tpu_r_w=0 and tpu_addr=0 (a harmless read).
- IDLE: job_ready=1. On job_valid, latch the three bases and clear the row counter; go to LD_A_REQ.
- LD_A_REQ / LD_A_WAIT (for row r):
  - Assert rd_valid with rd_addr=a_base+r until rd_ready.
  - Wait for rsp_valid, then write tpuv1 at 0x100+8r with rsp_data in that same cycle.
  - r increments; after r=DIM-1, clear r and go to LD_B_REQ.
- LD_B_REQ / LD_B_WAIT: same pattern with b_base+r; every write goes to 0x200; after DIM rows go to CLR_C.
- CLR_C:
  - 2*DIM consecutive cycles, each writing dataIn=0.
  - Cycle k targets 0x300 + 16*(k>>1) + 8*(k&1).
  - Then go to START.
- START: one cycle writing 0x400; load the wait counter with COMPUTE_CYCLES; go to COMPUTE.
- COMPUTE: decrement the wait counter each cycle. On the cycle it reaches 0, go to RD_C with k=0. There are no tpuv1 accesses during COMPUTE.
- RD_C:
  - One cycle reading tpuv1 at C word k (same address formula as CLR_C).
  - Register tpu_dataOut into wr_data; set wr_addr=c_base+k; go to WR_C.
- WR_C:
  - Hold wr_valid, wr_addr and wr_data stable until wr_ready.
  - On accept: if k=2*DIM-1, pulse job_done and go to IDLE; otherwise k++ and go to RD_C.
- Read handshake: rd_valid drops the cycle after acceptance. rsp_valid arriving in the same cycle as rd_ready is legal and must be consumed.
- Overlap: rd_valid and wr_valid are never asserted together.
- job_ready=0 in every state except IDLE; job_valid while busy is ignored.
- Width rules: all address sums wrap modulo 2^MEM_AW. Counters are clog2(2*DIM)+1 bits; the wait counter is clog2(COMPUTE_CYCLES+1) bits.
- Latency with zero-wait memory (rd_ready=1, response one cycle later) and wr_ready=1, DIM=8: accept→job_done = 16*2 + 16 + 1 + 32 + 16*2 = 113 cycles ±1. The bench checks the exact count.

Decomposition:
- Package tpu_seq_pkg holds:
  - the state enum (IDLE, LD_A_REQ, LD_A_WAIT, LD_B_REQ, LD_B_WAIT, CLR_C, START, COMPUTE, RD_C, WR_C);
  - address constants TPU_A_BASE=0x100, TPU_B_BASE=0x200, TPU_C_BASE=0x300, TPU_START=0x400;
  - a function c_word_addr(k) implementing the C word address formula.
- Single module; no sub-module. The FSM, row/word counter and wait counter are small enough to stay flat.

Test Plan:
- Reset then idle: job_ready=1; tpu_r_w=0, tpu_addr=0, rd_valid=0 and wr_valid=0 for 10 cycles.
- Identity A, B = row r all bytes r+1, zero-wait memory, a_base=0x10, b_base=0x20, c_base=0x40:
  - tpuv1 access trace is 0x100..0x138 step 8, then 0x200 ×8, then 16 C clears, then 0x400.
  - 16 memory writes at 0x40..0x4F match the tpuv1 C model.
  - job_done arrives exactly at the computed latency.
- Backpressure: rd_ready low for 3 cycles per request and wr_ready toggling → identical trace and data; wr_addr/wr_data stable while wr_valid && !wr_ready.
- Busy rejection: job_valid held high for the whole job → exactly one job accepted; job_ready=1 again only after the job_done pulse.
- Reset mid-job: assert rst_n=0 during COMPUTE → IDLE, job_ready=1, no writes issued; a fresh job then completes correctly.
- Address wrap: c_base=0xFFFF_FFF8, MEM_AW=32 → writes to 0xFFFF_FFF8..0xFFFF_FFFF, then 0x0..0x7.

Source files
------------

// File: rtl/tpu_seq_pkg.sv
// Shared state encoding and tpuv1 register map for the tpu_job_seq host-side sequencer.
package tpu_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LD_A_REQ,
    LD_A_WAIT,
    LD_B_REQ,
    LD_B_WAIT,
    CLR_C,
    START,
    COMPUTE,
    RD_C,
    WR_C
  } state_e;

  localparam logic [15:0] TPU_A_BASE = 16'h0100;
  localparam logic [15:0] TPU_B_BASE = 16'h0200;
  localparam logic [15:0] TPU_C_BASE = 16'h0300;
  localparam logic [15:0] TPU_START  = 16'h0400;

  // C row r keeps its low half at +16r and its high half at +16r+8; word k = 2r + half.
  function automatic logic [15:0] c_word_addr(input int unsigned k);
    return TPU_C_BASE + 16'(16 * (k >> 1)) + 16'(8 * (k & 1));
  endfunction

endpackage

// File: rtl/tpu_job_seq.sv
// Runs one tpuv1 job end to end: load A and B rows from memory, clear C, start,
// wait out the compute window, then copy the C words back to memory.
module tpu_job_seq
  import tpu_seq_pkg::*;
#(
  parameter int unsigned DIM            = 8,
  parameter int unsigned DATAW          = 64,
  parameter int unsigned ADDRW          = 16,
  parameter int unsigned MEM_AW         = 32,
  parameter int unsigned COMPUTE_CYCLES = 4 * DIM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [MEM_AW-1:0] a_base,
  input  logic [MEM_AW-1:0] b_base,
  input  logic [MEM_AW-1:0] c_base,
  output logic              job_done,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [MEM_AW-1:0] rd_addr,
  input  logic              rsp_valid,
  input  logic [DATAW-1:0]  rsp_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [DATAW-1:0]  wr_data,
  output logic              tpu_r_w,
  output logic [ADDRW-1:0]  tpu_addr,
  output logic [DATAW-1:0]  tpu_dataIn,
  input  logic [DATAW-1:0]  tpu_dataOut
);

  localparam int unsigned CNTW  = $clog2(2 * DIM) + 1;
  localparam int unsigned WAITW = $clog2(COMPUTE_CYCLES + 1);

  localparam logic [CNTW-1:0]  ROW_LAST  = CNTW'(DIM - 1);
  localparam logic [CNTW-1:0]  WORD_LAST = CNTW'(2 * DIM - 1);
  localparam logic [WAITW-1:0] WAIT_LOAD = WAITW'(COMPUTE_CYCLES);

  state_e              state_q;
  logic [MEM_AW-1:0]   a_base_q;
  logic [MEM_AW-1:0]   b_base_q;
  logic [MEM_AW-1:0]   c_base_q;
  logic [MEM_AW-1:0]   rd_addr_q;
  logic                rd_valid_q;
  logic [MEM_AW-1:0]   wr_addr_q;
  logic [DATAW-1:0]    wr_data_q;
  logic                wr_valid_q;
  logic [CNTW-1:0]     cnt_q;
  logic [WAITW-1:0]    wait_q;

  logic [CNTW-1:0]     cnt_inc;
  logic                rsp_take;
  logic                row_last;
  logic                word_last;

  assign cnt_inc   = cnt_q + CNTW'(1);
  assign row_last  = (cnt_q == ROW_LAST);
  assign word_last = (cnt_q == WORD_LAST);

  // A response is consumed in the WAIT state, or in the REQ state when the
  // memory answers in the same cycle it accepts the request.
  always_comb begin
    case (state_q)
      LD_A_REQ, LD_B_REQ:   rsp_take = rd_ready && rsp_valid;
      LD_A_WAIT, LD_B_WAIT: rsp_take = rsp_valid;
      default:              rsp_take = 1'b0;
    endcase
  end

  // The tpuv1 port is strobed for exactly one cycle per access and must carry
  // rsp_data in the cycle it arrives, so it is decoded rather than registered.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    tpu_r_w    = 1'b0;
    tpu_addr   = '0;
    tpu_dataIn = '0;
    case (state_q)
      LD_A_REQ, LD_A_WAIT: begin
        if (rsp_take) begin
          tpu_r_w    = 1'b1;
          tpu_addr   = ADDRW'(TPU_A_BASE + (16'(cnt_q) << 3));
          tpu_dataIn = rsp_data;
        end
      end
      LD_B_REQ, LD_B_WAIT: begin
        if (rsp_take) begin
          tpu_r_w    = 1'b1;
          tpu_addr   = ADDRW'(TPU_B_BASE);
          tpu_dataIn = rsp_data;
        end
      end
      CLR_C: begin
        tpu_r_w  = 1'b1;
        tpu_addr = ADDRW'(c_word_addr(32'(cnt_q)));
      end
      START: begin
        tpu_r_w  = 1'b1;
        tpu_addr = ADDRW'(TPU_START);
      end
      RD_C: begin
        tpu_addr = ADDRW'(c_word_addr(32'(cnt_q)));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; later ones in
    // the same branch deliberately override earlier ones.
    if (!rst_n) begin
      state_q    <= IDLE;
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_base_q   <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      cnt_q      <= '0;
      wait_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (job_valid) begin
            a_base_q   <= a_base;
            b_base_q   <= b_base;
            c_base_q   <= c_base;
            cnt_q      <= '0;
            rd_addr_q  <= a_base;
            rd_valid_q <= 1'b1;
            state_q    <= LD_A_REQ;
          end
        end

        LD_A_REQ, LD_A_WAIT: begin
          if (state_q == LD_A_REQ && rd_ready) begin
            rd_valid_q <= 1'b0;
            state_q    <= LD_A_WAIT;
          end
          if (rsp_take) begin
            rd_valid_q <= 1'b1;
            if (row_last) begin
              cnt_q     <= '0;
              rd_addr_q <= b_base_q;
              state_q   <= LD_B_REQ;
            end else begin
              cnt_q     <= cnt_inc;
              rd_addr_q <= a_base_q + MEM_AW'(cnt_inc);
              state_q   <= LD_A_REQ;
            end
          end
        end

        LD_B_REQ, LD_B_WAIT: begin
          if (state_q == LD_B_REQ && rd_ready) begin
            rd_valid_q <= 1'b0;
            state_q    <= LD_B_WAIT;
          end
          if (rsp_take) begin
            if (row_last) begin
              cnt_q      <= '0;
              rd_valid_q <= 1'b0;
              state_q    <= CLR_C;
            end else begin
              cnt_q      <= cnt_inc;
              rd_addr_q  <= b_base_q + MEM_AW'(cnt_inc);
              rd_valid_q <= 1'b1;
              state_q    <= LD_B_REQ;
            end
          end
        end

        CLR_C: begin
          if (word_last) begin
            cnt_q   <= '0;
            state_q <= START;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        START: begin
          wait_q  <= WAIT_LOAD;
          state_q <= COMPUTE;
        end

        COMPUTE: begin
          wait_q <= wait_q - WAITW'(1);
          if (wait_q <= WAITW'(1)) begin
            cnt_q   <= '0;
            state_q <= RD_C;
          end
        end

        RD_C: begin
          wr_data_q  <= tpu_dataOut;
          wr_addr_q  <= c_base_q + MEM_AW'(cnt_q);
          wr_valid_q <= 1'b1;
          state_q    <= WR_C;
        end

        WR_C: begin
          if (wr_ready) begin
            wr_valid_q <= 1'b0;
            if (word_last) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_inc;
              state_q <= RD_C;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign job_ready = (state_q == IDLE);
  assign job_done  = (state_q == WR_C) && wr_ready && word_last;
  assign rd_valid  = rd_valid_q;
  assign rd_addr   = rd_addr_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_tpu_job_seq.sv
// Self-checking bench for tpu_job_seq: behavioural memory, a stand-in tpuv1 and
// expected traffic derived directly from the job descriptor and memory contents.
module tb_tpu_job_seq;

  localparam int DIM = 8;
  localparam int NW  = 2 * DIM;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] a_base = '0;
  logic [31:0] b_base = '0;
  logic [31:0] c_base = '0;
  logic        job_done;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_addr;
  logic        rsp_valid = 1'b0;
  logic [63:0] rsp_data = '0;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic        tpu_r_w;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_dataIn;
  logic [63:0] tpu_dataOut;

  tpu_job_seq #(
    .DIM(DIM), .DATAW(64), .ADDRW(16), .MEM_AW(32), .COMPUTE_CYCLES(4 * DIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .job_done(job_done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn), .tpu_dataOut(tpu_dataOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [63:0] data;
  } acc_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } mw_t;

  int checks = 0;
  int errors = 0;

  // Memory side: 0 = zero-wait, 1 = backpressure, 2 = same-cycle response.
  int          mode = 0;
  logic [63:0] mem [logic [31:0]];
  bit          pending = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          hold = 0;

  // Stand-in tpuv1: C accumulates A+B (low) and A^B (high) per row on start.
  logic [63:0] tpu_a [DIM];
  logic [63:0] tpu_b [DIM];
  logic [63:0] tpu_c [NW];

  acc_t trace[$];
  mw_t  wq[$];
  int   cyc = 0;
  int   accept_cyc = 0;
  int   done_cyc = 0;
  int   accepts = 0;
  bit   done_seen = 0;
  bit   start_seen = 0;
  bit   busy = 0;
  int   busy_ready_viol = 0;
  int   overlap_viol = 0;
  int   stab_viol = 0;
  bit   wr_stalled = 0;
  logic [31:0] prev_waddr = '0;
  logic [63:0] prev_wdata = '0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  always_comb begin
    tpu_dataOut = '0;
    if (tpu_addr >= 16'h0300 && tpu_addr < 16'h0380)
      tpu_dataOut = tpu_c[(int'(tpu_addr) - 'h300) / 8];
  end

  task automatic tpu_write(input logic [15:0] addr, input logic [63:0] data);
    if (addr >= 16'h0100 && addr < 16'h0140) begin
      tpu_a[(int'(addr) - 'h100) / 8] = data;
    end else if (addr == 16'h0200) begin
      for (int i = 0; i < DIM - 1; i++) tpu_b[i] = tpu_b[i + 1];
      tpu_b[DIM - 1] = data;
    end else if (addr >= 16'h0300 && addr < 16'h0380) begin
      tpu_c[(int'(addr) - 'h300) / 8] = data;
    end else if (addr == 16'h0400) begin
      for (int r = 0; r < DIM; r++) begin
        tpu_c[2 * r]     = tpu_c[2 * r] + (tpu_a[r] + tpu_b[r]);
        tpu_c[2 * r + 1] = tpu_c[2 * r + 1] + (tpu_a[r] ^ tpu_b[r]);
      end
    end
  endtask

  // Environment: drive memory inputs on the falling edge, observe 3 time units later.
  initial begin
    for (int i = 0; i < NW; i++) tpu_c[i] = {$urandom, $urandom};
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_data  = '0;
      if (pending) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data  = mem[pend_addr];
          pending   = 0;
        end
      end
      case (mode)
        1: rd_ready = rd_valid && (hold >= 3);
        2: begin
          rd_ready = 1'b1;
          if (rd_valid) begin
            rsp_valid = 1'b1;
            rsp_data  = mem[rd_addr];
          end
        end
        default: rd_ready = 1'b1;
      endcase
      if (rd_valid) hold++;
      wr_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      cyc++;
      if (tpu_r_w || tpu_addr != 16'h0) begin
        acc_t e;
        e.rw   = tpu_r_w;
        e.addr = tpu_addr;
        e.data = tpu_r_w ? tpu_dataIn : 64'h0;
        trace.push_back(e);
        if (tpu_r_w) tpu_write(tpu_addr, tpu_dataIn);
        if (tpu_r_w && tpu_addr == 16'h0400) start_seen = 1;
      end
      if (rd_valid && rd_ready) begin
        hold = 0;
        if (mode != 2) begin
          pending   = 1;
          pend_cnt  = (mode == 1) ? $urandom_range(1, 3) : 1;
          pend_addr = rd_addr;
        end
      end
      if (rd_valid && wr_valid) overlap_viol++;
      if (wr_stalled && (!wr_valid || wr_addr !== prev_waddr || wr_data !== prev_wdata)) stab_viol++;
      wr_stalled = wr_valid && !wr_ready;
      prev_waddr = wr_addr;
      prev_wdata = wr_data;
      if (wr_valid && wr_ready) begin
        mw_t w;
        w.addr = wr_addr;
        w.data = wr_data;
        wq.push_back(w);
      end
      if (busy && job_ready) busy_ready_viol++;
      if (job_valid && job_ready && rst_n) begin
        accepts++;
        accept_cyc = cyc;
        busy = 1;
      end
      if (job_done) begin
        done_cyc  = cyc;
        done_seen = 1;
        busy      = 0;
      end
    end
  end

  task automatic fill(input logic [31:0] a, input logic [31:0] b, input bit identity);
    for (int r = 0; r < DIM; r++) begin
      mem[a + 32'(r)] = identity ? (64'h1 << (8 * r)) : {$urandom, $urandom};
      mem[b + 32'(r)] = identity ? {8{8'(r + 1)}} : {$urandom, $urandom};
    end
  endtask

  task automatic clear_obs();
    trace.delete();
    wq.delete();
    accepts = 0;
    done_seen = 0;
    start_seen = 0;
    busy_ready_viol = 0;
    overlap_viol = 0;
    stab_viol = 0;
  endtask

  task automatic verify(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input string tag);
    acc_t exp_t[$];
    mw_t  exp_w[$];
    acc_t e;
    mw_t  w;
    for (int r = 0; r < DIM; r++) begin
      e.rw = 1'b1; e.addr = 16'(16'h100 + 8 * r); e.data = mem[a + 32'(r)];
      exp_t.push_back(e);
    end
    for (int r = 0; r < DIM; r++) begin
      e.rw = 1'b1; e.addr = 16'h0200; e.data = mem[b + 32'(r)];
      exp_t.push_back(e);
    end
    for (int k = 0; k < NW; k++) begin
      e.rw = 1'b1; e.addr = 16'(16'h300 + 8 * k); e.data = 64'h0;
      exp_t.push_back(e);
    end
    e.rw = 1'b1; e.addr = 16'h0400; e.data = 64'h0;
    exp_t.push_back(e);
    for (int k = 0; k < NW; k++) begin
      e.rw = 1'b0; e.addr = 16'(16'h300 + 8 * k); e.data = 64'h0;
      exp_t.push_back(e);
    end
    for (int k = 0; k < NW; k++) begin
      logic [63:0] av, bv;
      av = mem[a + 32'(k / 2)];
      bv = mem[b + 32'(k / 2)];
      w.addr = c + 32'(k);
      w.data = (k % 2 == 0) ? av + bv : av ^ bv;
      exp_w.push_back(w);
    end
    check($sformatf("%s_trace_len", tag), 96'(trace.size()), 96'(exp_t.size()));
    for (int i = 0; i < exp_t.size() && i < trace.size(); i++)
      check($sformatf("%s_tpu_access_%0d", tag, i), 96'(trace[i]), 96'(exp_t[i]));
    check($sformatf("%s_write_count", tag), 96'(wq.size()), 96'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wq.size(); i++)
      check($sformatf("%s_mem_write_%0d", tag, i), 96'(wq[i]), 96'(exp_w[i]));
    check($sformatf("%s_overlap", tag), 96'(overlap_viol), 96'(0));
    check($sformatf("%s_wr_stable", tag), 96'(stab_viol), 96'(0));
  endtask

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input bit hold_valid, input int exp_lat, input string tag);
    int n;
    clear_obs();
    @(negedge clk);
    a_base = a; b_base = b; c_base = c;
    job_valid = 1'b1;
    n = 0;
    while (accepts == 0 && n < 50) begin @(negedge clk); n++; end
    check($sformatf("%s_accepted", tag), 96'(accepts != 0), 96'(1));
    if (!hold_valid) job_valid = 1'b0;
    n = 0;
    while (!done_seen && n < 3000) begin @(negedge clk); n++; end
    job_valid = 1'b0;
    check($sformatf("%s_done", tag), 96'(done_seen), 96'(1));
    #3;
    check($sformatf("%s_ready_after_done", tag), 96'(job_ready), 96'(1));
    check($sformatf("%s_accept_count", tag), 96'(accepts), 96'(1));
    check($sformatf("%s_busy_ready", tag), 96'(busy_ready_viol), 96'(0));
    if (exp_lat >= 0)
      check($sformatf("%s_latency", tag), 96'(done_cyc - accept_cyc), 96'(exp_lat));
    verify(a, b, c, tag);
  endtask

  initial begin
    int n;
    int trace_at_reset;
    logic [31:0] ra, rb, rc;

    repeat (3) @(negedge clk);
    #3;
    check("reset_outputs",
          96'({job_ready, job_done, rd_valid, wr_valid, tpu_r_w, tpu_addr, tpu_dataIn}),
          96'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0}));
    check("reset_addr_regs", 96'({rd_addr, wr_addr}), 96'(0));
    check("reset_wr_data", 96'(wr_data), 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #3;
      check($sformatf("idle_%0d", i),
            96'({job_ready, tpu_r_w, tpu_addr, rd_valid, wr_valid, job_done}),
            96'({1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}));
    end

    mode = 0;
    fill(32'h10, 32'h20, 1'b1);
    run_job(32'h10, 32'h20, 32'h40, 1'b0, 113, "identity");

    mode = 1;
    ra = $urandom & 32'h0FFF_FF00;
    rb = ra + 32'h0000_0100;
    rc = $urandom;
    fill(ra, rb, 1'b0);
    run_job(ra, rb, rc, 1'b0, -1, "backpressure");

    mode = 0;
    ra = $urandom & 32'h0FFF_FF00;
    rb = ra + 32'h0000_0200;
    fill(ra, rb, 1'b0);
    run_job(ra, rb, 32'h0000_8000, 1'b1, 113, "busy_hold");

    // Abandon a job part-way through the compute window.
    mode = 0;
    fill(32'h300, 32'h400, 1'b0);
    clear_obs();
    @(negedge clk);
    a_base = 32'h300; b_base = 32'h400; c_base = 32'h500;
    job_valid = 1'b1;
    n = 0;
    while (accepts == 0 && n < 50) begin @(negedge clk); n++; end
    job_valid = 1'b0;
    check("midreset_accepted", 96'(accepts), 96'(1));
    n = 0;
    while (!start_seen && n < 500) begin @(negedge clk); n++; end
    check("midreset_reached_compute", 96'(start_seen), 96'(1));
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    busy = 0;
    #3;
    check("midreset_idle",
          96'({job_ready, rd_valid, wr_valid, tpu_r_w, tpu_addr}),
          96'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0}));
    trace_at_reset = trace.size();
    repeat (40) @(negedge clk);
    check("midreset_no_writes", 96'(wq.size()), 96'(0));
    check("midreset_no_tpu_access", 96'(trace.size()), 96'(trace_at_reset));

    mode = 2;
    fill(32'h300, 32'h400, 1'b0);
    run_job(32'h300, 32'h400, 32'h500, 1'b0, -1, "after_reset");

    mode = 0;
    fill(32'h1000, 32'h2000, 1'b0);
    run_job(32'h1000, 32'h2000, 32'hFFFF_FFF8, 1'b0, 113, "wrap");
    if (wq.size() > 8) check("wrap_word8_addr", 96'(wq[8].addr), 96'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
